// File: rtl/reg_file_banked_if.sv
// Decode/execute/fetch bundle for the banked ARM register file.
interface reg_file_banked_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_MODES = 4
);
  localparam int unsigned MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;

  logic [MODE_W-1:0] mode;
  logic [3:0]        ARn, ARs, ARm, ARd;
  logic [DATA_W-1:0] Rn, Rs, Rm, Rd;
  logic              wen_ARd;
  logic [DATA_W-1:0] Rd_data;
  logic              wen_ARb;
  logic [3:0]        ARb;
  logic [DATA_W-1:0] Rb_data;
  logic              pc_en;
  logic [DATA_W-1:0] PC_next;
  logic [DATA_W-1:0] PC_out;

  modport master (
    output mode, ARn, ARs, ARm, ARd, wen_ARd, Rd_data, wen_ARb, ARb, Rb_data,
           pc_en, PC_next,
    input  Rn, Rs, Rm, Rd, PC_out
  );

  modport slave (
    input  mode, ARn, ARs, ARm, ARd, wen_ARd, Rd_data, wen_ARb, ARb, Rb_data,
           pc_en, PC_next,
    output Rn, Rs, Rm, Rd, PC_out
  );
endinterface

// File: rtl/reg_file_banked.sv
// ARM integer register file: R0-R12 shared, R13/R14 banked per mode, separate PC.
// Four zero-latency read ports, two write ports (A wins collisions), optional bypass.
module reg_file_banked #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       N_MODES   = 4,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter int unsigned       PC_RD_OFF = 8,
  parameter bit                BYPASS    = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  reg_file_banked_if.slave bus
);
  localparam int unsigned MODE_W   = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int unsigned N_SHARED = 13;
  localparam int unsigned N_RD     = 4;
  localparam logic [3:0]  SP_ADDR  = 4'd13;
  localparam logic [3:0]  LR_ADDR  = 4'd14;
  localparam logic [3:0]  PC_ADDR  = 4'd15;

  logic [DATA_W-1:0] shared_q [N_SHARED];
  logic [DATA_W-1:0] shared_d [N_SHARED];
  logic [DATA_W-1:0] sp_q     [N_MODES];
  logic [DATA_W-1:0] sp_d     [N_MODES];
  logic [DATA_W-1:0] lr_q     [N_MODES];
  logic [DATA_W-1:0] lr_d     [N_MODES];
  logic [DATA_W-1:0] pc_q, pc_d;

  logic [MODE_W-1:0] mode_eff;
  logic              wb_en;
  logic [3:0]        rd_addr [N_RD];
  logic [DATA_W-1:0] rd_val  [N_RD];

  // Anything written to the PC is word aligned.
  function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] v);
    return v & ~DATA_W'(3);
  endfunction

  // Out-of-range mode encodings fall back to the user bank.
  generate
    if (N_MODES == (1 << MODE_W)) begin : g_mode_full
      assign mode_eff = bus.mode;
    end else begin : g_mode_clip
      assign mode_eff = (32'(bus.mode) < N_MODES) ? bus.mode : '0;
    end
  endgenerate

  // Port B is dropped when port A targets the same register.
  assign wb_en = bus.wen_ARb && !(bus.wen_ARd && (bus.ARb == bus.ARd));

  // Read mux: PC view with offset, then same-cycle forwarding, then storage.
  always_comb begin
    rd_addr[0] = bus.ARn;
    rd_addr[1] = bus.ARs;
    rd_addr[2] = bus.ARm;
    rd_addr[3] = bus.ARd;
    for (int p = 0; p < int'(N_RD); p++) begin
      rd_val[p] = '0;
      if (rd_addr[p] == PC_ADDR)
        rd_val[p] = pc_q + DATA_W'(PC_RD_OFF);
      else if (BYPASS && rst_n && bus.wen_ARd && (bus.ARd == rd_addr[p]))
        rd_val[p] = bus.Rd_data;
      else if (BYPASS && rst_n && wb_en && (bus.ARb == rd_addr[p]))
        rd_val[p] = bus.Rb_data;
      else if (rd_addr[p] == SP_ADDR)
        rd_val[p] = sp_q[mode_eff];
      else if (rd_addr[p] == LR_ADDR)
        rd_val[p] = lr_q[mode_eff];
      else
        rd_val[p] = shared_q[rd_addr[p]];
    end
  end

  assign bus.Rn     = rd_val[0];
  assign bus.Rs     = rd_val[1];
  assign bus.Rm     = rd_val[2];
  assign bus.Rd     = rd_val[3];
  assign bus.PC_out = pc_q;

  // Next-state: pc_en lowest, port B next, port A applied last so it wins.
  always_comb begin
    shared_d = shared_q;
    sp_d     = sp_q;
    lr_d     = lr_q;
    pc_d     = pc_q;
    if (bus.pc_en) pc_d = align(bus.PC_next);
    if (wb_en) begin
      if (bus.ARb == PC_ADDR)      pc_d = align(bus.Rb_data);
      else if (bus.ARb == SP_ADDR) sp_d[mode_eff] = bus.Rb_data;
      else if (bus.ARb == LR_ADDR) lr_d[mode_eff] = bus.Rb_data;
      else                         shared_d[bus.ARb] = bus.Rb_data;
    end
    if (bus.wen_ARd) begin
      if (bus.ARd == PC_ADDR)      pc_d = align(bus.Rd_data);
      else if (bus.ARd == SP_ADDR) sp_d[mode_eff] = bus.Rd_data;
      else if (bus.ARd == LR_ADDR) lr_d[mode_eff] = bus.Rd_data;
      else                         shared_d[bus.ARd] = bus.Rd_data;
    end
  end

  // Register state; asynchronous reset clears everything and discards pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SHARED); i++) shared_q[i] <= '0;
      for (int m = 0; m < int'(N_MODES); m++) begin
        sp_q[m] <= '0;
        lr_q[m] <= '0;
      end
      pc_q <= RESET_PC;
    end else begin
      shared_q <= shared_d;
      sp_q     <= sp_d;
      lr_q     <= lr_d;
      pc_q     <= pc_d;
    end
  end
endmodule

// File: tb/tb_reg_file_banked.sv
// Directed bench for reg_file_banked: bypassing and non-bypassing instances share stimulus.
module tb_reg_file_banked;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  reg_file_banked_if #(.DATA_W(32), .N_MODES(4)) b1 ();
  reg_file_banked_if #(.DATA_W(32), .N_MODES(4)) b0 ();

  reg_file_banked #(.DATA_W(32), .N_MODES(4), .RESET_PC(32'd0), .PC_RD_OFF(8), .BYPASS(1'b1))
    u_byp (.clk(clk), .rst_n(rst_n), .bus(b1));
  reg_file_banked #(.DATA_W(32), .N_MODES(4), .RESET_PC(32'd0), .PC_RD_OFF(8), .BYPASS(1'b0))
    u_nob (.clk(clk), .rst_n(rst_n), .bus(b0));

  // Non-bypass instance mirrors the stimulus of the bypass instance.
  assign b0.mode    = b1.mode;
  assign b0.ARn     = b1.ARn;
  assign b0.ARs     = b1.ARs;
  assign b0.ARm     = b1.ARm;
  assign b0.ARd     = b1.ARd;
  assign b0.wen_ARd = b1.wen_ARd;
  assign b0.Rd_data = b1.Rd_data;
  assign b0.wen_ARb = b1.wen_ARb;
  assign b0.ARb     = b1.ARb;
  assign b0.Rb_data = b1.Rb_data;
  assign b0.pc_en   = b1.pc_en;
  assign b0.PC_next = b1.PC_next;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned mode, arn, ars, arm, ard;
    int unsigned wa, da, wb, ab, db, pe, pn;
    int unsigned ern, ers, erm, erd, epc, ernb;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input int unsigned exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, 32'(exp));
    end
  endtask

  task automatic drive(input vec_t v);
    b1.mode    = 2'(v.mode);
    b1.ARn     = 4'(v.arn);
    b1.ARs     = 4'(v.ars);
    b1.ARm     = 4'(v.arm);
    b1.ARd     = 4'(v.ard);
    b1.wen_ARd = 1'(v.wa);
    b1.Rd_data = 32'(v.da);
    b1.wen_ARb = 1'(v.wb);
    b1.ARb     = 4'(v.ab);
    b1.Rb_data = 32'(v.db);
    b1.pc_en   = 1'(v.pe);
    b1.PC_next = 32'(v.pn);
  endtask

  initial begin
    vec_t idle;
    n_checks = 0;
    n_err    = 0;

    //          mode arn ars arm ard  wa da       wb ab db      pe pn      ern     ers     erm     erd     epc     ernb
    vecs[0]  = '{0, 3, 15, 4, 3,    1, 356,     0, 0, 0,      0, 0,      356,    8,      0,      356,    0,      0};
    vecs[1]  = '{0, 3, 3, 15, 0,    0, 0,       0, 0, 0,      1, 12,     356,    356,    8,      0,      0,      356};
    vecs[2]  = '{0, 15, 0, 3, 15,   0, 0,       0, 0, 0,      0, 0,      20,     0,      356,    20,     12,     20};
    vecs[3]  = '{0, 15, 0, 3, 15,   1, 'h107,   0, 0, 0,      1, 16,     20,     0,      356,    20,     12,     20};
    vecs[4]  = '{0, 15, 0, 3, 0,    0, 0,       1, 15, 'h203, 1, 'h300,  'h10C,  0,      356,    0,      'h104,  'h10C};
    vecs[5]  = '{0, 15, 13, 0, 13,  1, 'h1000,  0, 0, 0,      0, 0,      'h208,  'h1000, 0,      'h1000, 'h200,  'h208};
    vecs[6]  = '{2, 13, 12, 0, 13,  1, 'h2000,  0, 0, 0,      0, 0,      'h2000, 0,      0,      'h2000, 'h200,  0};
    vecs[7]  = '{0, 13, 12, 14, 0,  0, 0,       1, 12, 'h55,  0, 0,      'h1000, 'h55,   0,      0,      'h200,  'h1000};
    vecs[8]  = '{2, 13, 12, 3, 5,   1, 36,      1, 5, 99,     0, 0,      'h2000, 'h55,   356,    36,     'h200,  'h2000};
    vecs[9]  = '{0, 5, 6, 5, 5,     1, 36,      1, 6, 99,     0, 0,      36,     99,     36,     36,     'h200,  36};
    vecs[10] = '{3, 6, 5, 13, 14,   1, 'hABC,   0, 0, 0,      0, 0,      99,     36,     0,      'hABC,  'h200,  99};
    vecs[11] = '{0, 14, 14, 13, 6,  0, 0,       0, 0, 0,      0, 0,      0,      0,      'h1000, 99,     'h200,  0};
    vecs[12] = '{3, 14, 15, 0, 0,   0, 0,       0, 0, 0,      0, 0,      'hABC,  'h208,  0,      0,      'h200,  'hABC};

    // Reset state
    idle = '{0, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst_n = 1'b0;
    drive(idle);
    #1;
    chk("reset_pc_out", b1.PC_out, 0);
    chk("reset_rn_r3", b1.Rn, 0);
    chk("reset_rs_r15", b1.Rs, 8);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors; outputs sampled 1 time unit after driving, before the edge
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_rn", i), b1.Rn, vecs[i].ern);
      chk($sformatf("v%0d_rs", i), b1.Rs, vecs[i].ers);
      chk($sformatf("v%0d_rm", i), b1.Rm, vecs[i].erm);
      chk($sformatf("v%0d_rd", i), b1.Rd, vecs[i].erd);
      chk($sformatf("v%0d_pc_out", i), b1.PC_out, vecs[i].epc);
      chk($sformatf("v%0d_rn_nobyp", i), b0.Rn, vecs[i].ernb);
    end

    // Hold for 10 cycles with no writes
    @(negedge clk);
    idle = '{0, 5, 6, 12, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(idle);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hold%0d_pc_out", c), b1.PC_out, 'h200);
    end
    chk("hold_r5", b1.Rn, 36);
    chk("hold_r6", b1.Rs, 99);
    chk("hold_r12", b1.Rm, 'h55);
    chk("hold_r15", b1.Rd, 'h208);

    // Reset mid-write discards the write and clears state immediately
    @(negedge clk);
    idle = '{0, 3, 15, 13, 3, 1, 'h777, 0, 0, 0, 1, 'h40, 0, 0, 0, 0, 0, 0};
    drive(idle);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc_out", b1.PC_out, 0);
    chk("midrst_rn_r3", b1.Rn, 0);
    chk("midrst_rs_r15", b1.Rs, 8);
    chk("midrst_rm_r13", b1.Rm, 0);
    @(negedge clk);
    idle = '{0, 3, 15, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(idle);
    rst_n = 1'b1;
    #1;
    chk("postrst_rn_r3", b1.Rn, 0);
    chk("postrst_pc_out", b1.PC_out, 0);
    chk("postrst_rm_r13", b1.Rm, 0);
    @(negedge clk);
    #1;
    chk("postrst_edge_rn_r3", b1.Rn, 0);
    chk("postrst_edge_pc_out", b1.PC_out, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
